// File: rtl/lens_shading_corrector.sv
// Radial lens-shading corrector: adds an offset proportional to the squared distance from the optical centre.
// Optional build macro LSC_ROUND_EN selects round-half-up of the offset instead of truncation.
module lens_shading_corrector #(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 32,
    parameter int V_ACTIVE = 32,
    parameter int CX       = 16,
    parameter int CY       = 16,
    parameter int COEF_W   = 8,
    parameter int SHIFT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              en,
    input  logic [COEF_W-1:0] coef,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_hsync,
    output logic              out_vsync
);

    localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DW   = ((XW > YW) ? XW : YW) + 1;
    localparam int SQW  = 2 * DW;
    localparam int R2W  = SQW + 1;
    localparam int PW   = R2W + COEF_W;
    localparam int SUMW = ((PW > DATA_W) ? PW : DATA_W) + 2;

    localparam logic [SUMW-1:0] MAX_PIX = SUMW'({DATA_W{1'b1}});
`ifdef LSC_ROUND_EN
    localparam logic [SUMW-1:0] ROUND_C = (SHIFT > 0) ? (SUMW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [COEF_W-1:0] coef_q;
    logic              x_last;
    logic              y_last;
    logic              frame_first;
    logic [COEF_W-1:0] coef_eff;

    logic signed [DW-1:0]  dx;
    logic signed [DW-1:0]  dy;
    logic signed [SQW-1:0] dx_ext;
    logic signed [SQW-1:0] dy_ext;
    logic signed [SQW-1:0] dx_sq;
    logic signed [SQW-1:0] dy_sq;
    logic [R2W-1:0]        r2;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_en;
    logic [R2W-1:0]    s1_r2;
    logic [COEF_W-1:0] s1_coef;
    logic              s1_hsync;
    logic              s1_vsync;

    logic [PW-1:0]     prod;
    logic [SUMW-1:0]   off_w;
    logic [SUMW-1:0]   sum_w;
    logic [DATA_W-1:0] sat_data;

    assign x_last      = (x == XW'(H_ACTIVE - 1));
    assign y_last      = (y == YW'(V_ACTIVE - 1));
    assign frame_first = (x == '0) && (y == '0);
    // The first pixel of a frame already sees the coefficient being loaded on this edge.
    assign coef_eff    = frame_first ? coef : coef_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            coef_q <= '0;
        end else if (in_valid) begin
            if (frame_first) begin
                coef_q <= coef;
            end
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_comb begin
        dx     = $signed(DW'(x)) - $signed(DW'(CX));
        dy     = $signed(DW'(y)) - $signed(DW'(CY));
        dx_ext = SQW'(dx);
        dy_ext = SQW'(dy);
        dx_sq  = dx_ext * dx_ext;
        dy_sq  = dy_ext * dy_ext;
        r2     = {1'b0, dx_sq} + {1'b0, dy_sq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_en    <= 1'b0;
            s1_r2    <= '0;
            s1_coef  <= '0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= in_data;
                s1_en    <= en;
                s1_r2    <= r2;
                s1_coef  <= coef_eff;
                s1_hsync <= x_last;
                s1_vsync <= x_last && y_last;
            end
        end
    end

    // The sum is wide enough that neither the offset nor the rounding add can wrap before saturation.
    always_comb begin
        prod = PW'(s1_r2) * PW'(s1_coef);
`ifdef LSC_ROUND_EN
        off_w = (SUMW'(prod) + ROUND_C) >> SHIFT;
`else
        off_w = SUMW'(prod) >> SHIFT;
`endif
        sum_w    = SUMW'(s1_data) + off_w;
        sat_data = (sum_w > MAX_PIX) ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_hsync <= s1_valid && s1_hsync;
            out_vsync <= s1_valid && s1_vsync;
            if (s1_valid) begin
                out_data <= s1_en ? sat_data : s1_data;
            end
        end
    end

endmodule

// File: tb/tb_lens_shading_corrector.sv
// Scoreboard bench for lens_shading_corrector: random frames with bubbles checked against a frame-index model.
module tb_lens_shading_corrector;

    localparam int H     = 32;
    localparam int V     = 32;
    localparam int CX    = 16;
    localparam int CY    = 16;
    localparam int SHIFT = 8;
`ifdef LSC_ROUND_EN
    localparam longint RND = 1 << (SHIFT - 1);
`else
    localparam longint RND = 0;
`endif

    typedef struct {
        int data;
        int hs;
        int vs;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       en = 1'b0;
    logic [7:0] coef = '0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_hsync;
    logic       out_vsync;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   m_idx = 0;
    int   m_coef = 0;
    bit   pattern[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    lens_shading_corrector dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .en       (en),
        .coef     (coef),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_hsync(out_hsync),
        .out_vsync(out_vsync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: position comes from the pixel's index within the frame, offset from the radial formula.
    function automatic int modelPixel(input int idx, input int d, input bit e, input int c);
        int     px, py, s;
        longint r2, off;
        px  = idx % H;
        py  = idx / H;
        r2  = longint'((px - CX) * (px - CX) + (py - CY) * (py - CY));
        off = (r2 * c + RND) >> SHIFT;
        s   = d + int'(off);
        if (!e) return d;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit e, input logic [7:0] c);
        exp_t item;
        in_valid = v;
        in_data  = d;
        en       = e;
        coef     = c;
        if (v && !rst) begin
            if (m_idx == 0) m_coef = int'(c);
            item.data = modelPixel(m_idx, int'(d), e, m_coef);
            item.hs   = ((m_idx % H) == H - 1) ? 1 : 0;
            item.vs   = (m_idx == H * V - 1) ? 1 : 0;
            item.cyc  = cyc + 2;
            sb_q.push_back(item);
            m_idx = (m_idx + 1) % (H * V);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles, input bit with_valid);
        rst = 1'b1;
        repeat (cycles) applyStimulus(with_valid, 8'd77, 1'b1, 8'd99);
        sb_q.delete();
        m_idx  = 0;
        m_coef = 0;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_out_hsync", 32'(out_hsync), 0);
        checkOutput("rst_out_vsync", 32'(out_vsync), 0);
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    // Fixed probe pixels: (0,0) takes first_data/first_en, (16,16) and (1,16) get known values in random mode.
    task automatic runPixels(input int count, input bit bubbles, input logic [7:0] coef_val,
                             input bit rnd, input logic [7:0] first_data, input bit first_en);
        int         sent = 0;
        int         phase = 0;
        logic [7:0] d, c;
        bit         e, v;
        while (sent < count) begin
            v = bubbles ? pattern[phase % 5] : 1'b1;
            phase++;
            if (v) begin
                d = rnd ? 8'($urandom_range(0, 255)) : 8'd100;
                e = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                c = rnd ? 8'($urandom_range(0, 255)) : coef_val;
                if (m_idx == 0) begin
                    d = first_data;
                    e = first_en;
                    c = coef_val;
                end else if (rnd && m_idx == 16 * H + 16) begin
                    d = 8'd100;
                    e = 1'b1;
                end else if (rnd && m_idx == 16 * H + 1) begin
                    d = 8'd0;
                    e = 1'b1;
                end
                applyStimulus(1'b1, d, e, c);
                sent++;
            end else begin
                applyStimulus(1'b0, 8'($urandom), 1'($urandom), 8'($urandom));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'(out_valid), 0);
                end else begin
                    exp_t item;
                    item = sb_q.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(item.data));
                    checkOutput("out_hsync", 32'(out_hsync), 32'(item.hs));
                    checkOutput("out_vsync", 32'(out_vsync), 32'(item.vs));
                    checkOutput("latency_cycle", 32'(cyc), 32'(item.cyc));
                end
            end else begin
                checkOutput("idle_markers", {30'd0, out_hsync, out_vsync}, 0);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        doReset(2, 1'b0);
        mon_en = 1'b1;
        $display("[TB] zero coefficient frame");
        runPixels(H * V, 1'b0, 8'd0, 1'b0, 8'd100, 1'b1);
        $display("[TB] random frame with bubbles, coef 26");
        runPixels(H * V, 1'b1, 8'd26, 1'b1, 8'd100, 1'b1);
        $display("[TB] saturation at corner");
        runPixels(H * V, 1'b1, 8'd26, 1'b1, 8'd250, 1'b1);
        $display("[TB] bypass at corner, continuous frame");
        runPixels(H * V, 1'b0, 8'($urandom_range(1, 255)), 1'b1, 8'd250, 1'b0);
        $display("[TB] reset mid-frame");
        runPixels(500, 1'b1, 8'd26, 1'b1, 8'd100, 1'b1);
        doReset(1, 1'b1);
        runPixels(40, 1'b1, 8'd26, 1'b1, 8'd100, 1'b1);
        repeat (8) applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
